alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single 8-bit combinational `alu` between two requesters. It accepts operand/opcode requests over valid/ready handshakes, registers the operands, drives the ALU for one execute cycle and returns a tagged, registered result over a valid/ready response channel. It sits between the requesting datapaths and the existing `alu` instance, and is the only driver of the ALU's `A`, `B` and `ALU_Sel` inputs.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 37 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode constants and the arbiter FSM encoding.
package alu_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational DW-bit ALU; result is truncated to DW bits, no flags.
module alu #(
  parameter int unsigned DW = alu_pkg::DW,
  parameter int unsigned SW = alu_pkg::SW
) (
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [SW-1:0] ALU_Sel,
  output logic [DW-1:0] ALU_Out
);
  import alu_pkg::*;

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      ALU_ADD: ALU_Out = A + B;
      ALU_SUB: ALU_Out = A - B;
      ALU_MUL: ALU_Out = A * B;
      // Divide by zero yields zero rather than X
      ALU_DIV: ALU_Out = (B == '0) ? '0 : A / B;
      4'b0100: ALU_Out = A << 1;
      4'b0101: ALU_Out = A >> 1;
      4'b0110: ALU_Out = {A[DW-2:0], A[DW-1]};
      4'b0111: ALU_Out = {A[0], A[DW-1:1]};
      4'b1000: ALU_Out = A & B;
      4'b1001: ALU_Out = A | B;
      4'b1010: ALU_Out = A ^ B;
      4'b1011: ALU_Out = ~(A | B);
      4'b1100: ALU_Out = ~(A & B);
      4'b1101: ALU_Out = ~(A ^ B);
      4'b1110: ALU_Out = (A > B) ? DW'(1) : '0;
      4'b1111: ALU_Out = (A == B) ? DW'(1) : '0;
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one shared ALU and
// returns a registered, requester-tagged result over a valid/ready channel.
module alu_arbiter #(
  parameter int unsigned DW = alu_pkg::DW,
  parameter int unsigned SW = alu_pkg::SW
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid_0,
  output logic          req_ready_0,
  input  logic [DW-1:0] req_a_0,
  input  logic [DW-1:0] req_b_0,
  input  logic [SW-1:0] req_sel_0,

  input  logic          req_valid_1,
  output logic          req_ready_1,
  input  logic [DW-1:0] req_a_1,
  input  logic [DW-1:0] req_b_1,
  input  logic [SW-1:0] req_sel_1,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          busy
);
  import alu_pkg::*;

  state_e        state_q, state_d;
  logic [DW-1:0] op_a_q, op_b_q;
  logic [SW-1:0] op_sel_q;
  logic          op_id_q;
  logic          last_grant_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_id_q;

  logic          any_valid;
  logic          grant_id;
  logic          handshake;
  logic [DW-1:0] alu_out;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    any_valid = req_valid_0 | req_valid_1;
    grant_id  = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
    handshake = (state_q == ST_IDLE) && any_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are gated by rst so they drop immediately on an asynchronous reset.
  always_comb begin
    req_ready_0 = !rst && (state_q == ST_IDLE) && req_valid_0 && !grant_id;
    req_ready_1 = !rst && (state_q == ST_IDLE) && req_valid_1 && grant_id;
    busy        = (state_q != ST_IDLE);
    rsp_valid   = (state_q == ST_RESP);
    rsp_data    = rsp_data_q;
    rsp_id      = rsp_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      if (handshake) begin
        op_a_q       <= grant_id ? req_a_1 : req_a_0;
        op_b_q       <= grant_id ? req_b_1 : req_b_0;
        op_sel_q     <= grant_id ? req_sel_1 : req_sel_0;
        op_id_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= alu_out;
        rsp_id_q   <= op_id_q;
      end
    end
  end

  alu #(
    .DW(DW),
    .SW(SW)
  ) u_alu (
    .A      (op_a_q),
    .B      (op_b_q),
    .ALU_Sel(op_sel_q),
    .ALU_Out(alu_out)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; inputs change on the falling
// edge and outputs are sampled 1 ns later.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk, rst;
  logic       req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [7:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [3:0] req_sel_0, req_sel_1;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.DW(8), .SW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_0(req_valid_0),
    .req_ready_0(req_ready_0),
    .req_a_0    (req_a_0),
    .req_b_0    (req_b_0),
    .req_sel_0  (req_sel_0),
    .req_valid_1(req_valid_1),
    .req_ready_1(req_ready_1),
    .req_a_1    (req_a_1),
    .req_b_1    (req_b_1),
    .req_sel_1  (req_sel_1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 8'd0; req_b_0 = 8'd0; req_sel_0 = ALU_ADD;
    req_valid_1 = 1'b1; req_a_1 = 8'd0; req_b_1 = 8'd0; req_sel_1 = ALU_ADD;
    rsp_ready = 1'b1;
    #3;
    check("rst_ready0", req_ready_0, 0);
    check("rst_ready1", req_ready_1, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rst = 1'b0;

    // Single request from requester 0: 10 + 2
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 8'd10; req_b_0 = 8'd2; req_sel_0 = ALU_ADD;
    #1 check("t1_ready0", req_ready_0, 1);
    check("t1_ready1", req_ready_1, 0);
    @(negedge clk);
    req_valid_0 = 1'b0;
    #1 check("t1_exec_busy", busy, 1);
    check("t1_exec_valid", rsp_valid, 0);
    @(negedge clk);
    #1 check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 12);
    check("t1_id", rsp_id, 0);
    @(negedge clk);
    #1 check("t1_idle_busy", busy, 0);
    check("t1_idle_valid", rsp_valid, 0);

    // Tie after reset: r0 (10-2) first, then r1 (10+2), then r0 again
    do_reset();
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 8'd10; req_b_0 = 8'd2; req_sel_0 = ALU_SUB;
    req_valid_1 = 1'b1; req_a_1 = 8'd10; req_b_1 = 8'd2; req_sel_1 = ALU_ADD;
    #1 check("t2_tie1_ready0", req_ready_0, 1);
    check("t2_tie1_ready1", req_ready_1, 0);
    @(negedge clk);
    #1 check("t2_exec_ready0", req_ready_0, 0);
    check("t2_exec_ready1", req_ready_1, 0);
    @(negedge clk);
    #1 check("t2_rsp1_data", rsp_data, 8);
    check("t2_rsp1_id", rsp_id, 0);
    check("t2_rsp1_ready1", req_ready_1, 0);
    @(negedge clk);
    #1 check("t2_tie2_ready1", req_ready_1, 1);
    check("t2_tie2_ready0", req_ready_0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 check("t2_rsp2_data", rsp_data, 12);
    check("t2_rsp2_id", rsp_id, 1);
    @(negedge clk);
    #1 check("t2_tie3_ready0", req_ready_0, 1);
    check("t2_tie3_ready1", req_ready_1, 0);
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clk);
    #1 check("t2_rsp3_data", rsp_data, 8);
    check("t2_rsp3_id", rsp_id, 0);
    @(negedge clk);

    // Response backpressure: 7 * 3 held for 5 cycles
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 8'd7; req_b_0 = 8'd3; req_sel_0 = ALU_MUL;
    rsp_ready = 1'b0;
    #1 check("t3_ready0", req_ready_0, 1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    @(negedge clk);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1 check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_data", rsp_data, 21);
      check("t3_hold_id", rsp_id, 0);
      check("t3_hold_ready0", req_ready_0, 0);
      check("t3_hold_ready1", req_ready_1, 0);
    end
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; rsp_ready = 1'b1;
    #1 check("t3_release_valid", rsp_valid, 1);
    @(negedge clk);
    #1 check("t3_idle_busy", busy, 0);
    check("t3_idle_valid", rsp_valid, 0);

    // Operand change after accept must not affect the result
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 8'd10; req_b_0 = 8'd2; req_sel_0 = ALU_SUB;
    @(negedge clk);
    req_a_0 = 8'd99; req_valid_0 = 1'b0;
    @(negedge clk);
    #1 check("t4_data", rsp_data, 8);
    check("t4_valid", rsp_valid, 1);
    @(negedge clk);

    // Asynchronous reset during EXEC
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 8'd3; req_b_0 = 8'd4; req_sel_0 = ALU_ADD;
    @(negedge clk);
    req_valid_0 = 1'b0;
    #1 check("t5_exec_busy", busy, 1);
    #1 rst = 1'b1;
    #1 check("t5_async_busy", busy, 0);
    check("t5_async_valid", rsp_valid, 0);
    check("t5_async_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("t5_no_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1 check("t5_tie_ready0", req_ready_0, 1);
    check("t5_tie_ready1", req_ready_1, 0);
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clk);
    #1 check("t5_rsp_data", rsp_data, 7);
    check("t5_rsp_id", rsp_id, 0);
    @(negedge clk);

    // Back-to-back from requester 1: accepts every third cycle
    @(negedge clk);
    req_valid_1 = 1'b1; req_a_1 = 8'd5; req_b_1 = 8'd6; req_sel_1 = ALU_ADD;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1 check("t6_ready1", req_ready_1, (i % 3 == 0));
      check("t6_ready0", req_ready_0, 0);
      if (i % 3 == 2) begin
        check("t6_valid", rsp_valid, 1);
        check("t6_data", rsp_data, 11);
        check("t6_id", rsp_id, 1);
      end
    end
    @(negedge clk);
    req_valid_1 = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
